// File: rtl/vscpu_ram_responder.sv
// VerySimpleCPU RAM responder: clear, host load, then CPU run with 1-cycle reads.
// Optional CPU write protection of low memory under `RAM_WPROT_EN.
module vscpu_ram_responder #(
  parameter int              SIZE        = 14,
  parameter int              DEPTH       = 16384,
  parameter logic [SIZE-1:0] IO_ADDR     = SIZE'(14'h3FFF),
  parameter int              WPROT_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [SIZE-1:0] addr_toRAM,
  input  logic [31:0]     data_toRAM,
  output logic [31:0]     data_fromRAM,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [SIZE-1:0] ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  input  logic            ld_req,
  output logic            cpu_rst,
  output logic [31:0]     io_out,
  output logic            io_strobe,
  output logic            wp_fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE:0] DEPTH_L = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0] WPL     = (SIZE+1)'(WPROT_LIMIT);
  localparam logic [AW-1:0] CNT_END = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] cnt_q;

  logic          st_clear, st_load, st_run;
  logic          cpu_map, ld_map, cpu_lo;
  logic          blocked, cpu_we, io_hit;
  logic          wp_fault_q;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  assign st_clear = (state_q == S_CLEAR);
  assign st_load  = (state_q == S_LOAD);
  assign st_run   = (state_q == S_RUN);

  assign cpu_map = {1'b0, addr_toRAM} < DEPTH_L;
  assign ld_map  = {1'b0, ld_addr} < DEPTH_L;
  assign cpu_lo  = {1'b0, addr_toRAM} < WPL;

`ifdef RAM_WPROT_EN
  assign blocked = cpu_lo;
`else
  logic unused_cpu_lo;
  assign unused_cpu_lo = cpu_lo;
  assign blocked = 1'b0;
`endif

  assign cpu_we = st_run && wrEn && !blocked;
  assign io_hit = cpu_we && (addr_toRAM == IO_ADDR);

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    cpu_rst  = 1'b1;
    unique case (state_q)
      S_CLEAR: begin
        if (cnt_q == CNT_END)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last)
          state_d = S_RUN;
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        if (ld_req)
          state_d = S_LOAD;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Single write port shared by clear, host load and CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    unique case (1'b1)
      st_clear: mem_we = 1'b1;
      st_load: begin
        mem_we    = ld_valid && ld_map;
        mem_waddr = ld_addr[AW-1:0];
        mem_wdata = ld_data;
      end
      st_run: begin
        mem_we    = cpu_we && cpu_map;
        mem_waddr = addr_toRAM[AW-1:0];
        mem_wdata = data_toRAM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      data_fromRAM <= '0;
      io_out       <= '0;
      io_strobe    <= 1'b0;
      wp_fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (st_clear)
        cnt_q <= cnt_q + AW'(1);
      else
        cnt_q <= '0;
      // Read-first: sees the value before a same-cycle write.
      if (st_run && cpu_map)
        data_fromRAM <= mem[addr_toRAM[AW-1:0]];
      else
        data_fromRAM <= '0;
      io_strobe <= io_hit;
      if (io_hit)
        io_out <= data_toRAM;
      wp_fault_q <= st_run && wrEn && blocked;
    end
  end

  assign wp_fault = wp_fault_q;

endmodule

// File: doc/vscpu_ram_responder.md
Name: vscpu_ram_responder

Overview:
- Memory-side responder for the VerySimpleCPU RAM port (wrEn / addr_toRAM / data_toRAM in, data_fromRAM out).
- Provides word-addressed storage with one-cycle registered read latency, which the CPU fetch/operand states depend on.
- Adds a boot sequencer: clears memory, accepts a program from a host load port while holding the CPU in reset, then releases it.
- Provides one memory-mapped output register for observing program results.

Parameters:
- SIZE, 14, address width; matches the CPU's SIZE.
- DEPTH, 16384, implemented words (≤ 2^SIZE); addresses ≥ DEPTH are unmapped.
- IO_ADDR, 14'h3FFF, address of the memory-mapped output register.
- WPROT_LIMIT, 64, with RAM_WPROT_EN: CPU writes to addresses < WPROT_LIMIT are blocked.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wrEn  in  1  CPU write enable.
- addr_toRAM  in  SIZE  CPU address.
- data_toRAM  in  32  CPU write data.
- data_fromRAM  out  32  registered read data to the CPU.
- ld_valid  in  1  host load word valid.
- ld_ready  out  1  responder accepts load word.
- ld_addr  in  SIZE  host load address.
- ld_data  in  32  host load data.
- ld_last  in  1  qualifies the final load word.
- ld_req  in  1  in RUN: stop the CPU and re-enter LOAD.
- cpu_rst  out  1  active-high synchronous reset to the CPU.
- io_out  out  32  memory-mapped output register.
- io_strobe  out  1  one-cycle pulse when io_out is written.
- wp_fault  out  1  write-protect violation pulse (RAM_WPROT_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, async):
  - state=CLEAR, clear counter=0.
  - data_fromRAM=0, io_out=0, io_strobe=0, wp_fault=0, ld_ready=0, cpu_rst=1.
- FSM states: CLEAR, LOAD, RUN.
- CLEAR:
  - Writes 0 to mem[cnt] each cycle, cnt 0..DEPTH-1.
  - After the write of DEPTH-1, moves to LOAD next cycle, so the clear takes exactly DEPTH cycles.
  - CPU port and load port are ignored; data_fromRAM=0.
- LOAD:
  - ld_ready=1 and cpu_rst=1.
  - Transfer occurs when ld_valid&&ld_ready at a rising edge: mem[ld_addr] <= ld_data.
  - ld_addr ≥ DEPTH: word is dropped but still handshaken.
  - A transfer with ld_last=1 moves the FSM to RUN. From the next cycle, ld_ready=0 and cpu_rst=0.
- RUN:
  - cpu_rst=0, ld_ready=0.
  - Every cycle: data_fromRAM <= (addr_toRAM < DEPTH) ? mem[addr_toRAM] : 0.
  - Data is valid the cycle after the address is presented; latency exactly 1.
  - wrEn=1: mem[addr_toRAM] <= data_toRAM if address < DEPTH.
  - Read-during-write to the same address returns the OLD data (read-first).
  - Write with addr_toRAM==IO_ADDR: io_out <= data_toRAM and io_strobe=1 for the following cycle only. The RAM word is also written if mapped.
  - ld_req=1 sampled → LOAD next cycle; cpu_rst=1 from that cycle. Memory is not re-cleared.
  - ld_req has priority over a same-cycle CPU write; that write is still performed.
- Reset mid-LOAD or mid-RUN: returns to CLEAR and wipes memory; io_out is cleared.
- The CPU port is ignored outside RUN.

Optional Feature:
- Macro RAM_WPROT_EN.
- Defined: in RUN, a CPU write with addr_toRAM < WPROT_LIMIT is suppressed (RAM and io_out unchanged), and wp_fault pulses 1 for the next cycle. Host loads are never protected.
- Undefined: all CPU writes are performed; wp_fault is constant 0.

Test Plan:
- Reset release, DEPTH=16 → ld_ready rises after exactly 16 clocks, cpu_rst=1 throughout; a word never loaded reads 0 in RUN.
- Load mem[0]=32'h1234, mem[5]=7 (ld_last on 2nd word) → cpu_rst falls the cycle after the last handshake; addr_toRAM=5 gives data_fromRAM=7 one cycle later.
- RUN: wrEn=1, addr=3, data=32'hDEAD; same cycle read addr 3 → old value; next-cycle read → 32'hDEAD.
- RUN: write 32'h55 to IO_ADDR → io_out=32'h55, io_strobe high exactly one cycle.
- RUN: assert ld_req → cpu_rst=1 and ld_ready=1 next cycle; reload mem[5]=9 with ld_last → reads 9. Assert rst mid-load → CLEAR restarts and io_out=0.
- RAM_WPROT_EN, WPROT_LIMIT=4: write 1 to addr 2 → wp_fault pulse and addr 2 unchanged; write to addr 4 succeeds with no fault.
